// File: rtl/axil_wb_bridge.sv
// axil_wb_bridge: AXI4-Lite slave to Wishbone classic master.
// AW, W and AR are each captured into a one-entry holding register.
// Reads and writes take turns when both are ready to issue.
// Only one Wishbone cycle is in flight at a time.
// A slave that never answers is closed out with a DECERR response.
module axil_wb_bridge #(
    parameter int AW      = 13,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   i_awaddr,
    input  logic            i_awvalid,
    output logic            o_awready,
    input  logic [DW-1:0]   i_wdata,
    input  logic [DW/8-1:0] i_wstrb,
    input  logic            i_wvalid,
    output logic            o_wready,
    output logic [1:0]      o_bresp,
    output logic            o_bvalid,
    input  logic            i_bready,
    input  logic [AW-1:0]   i_araddr,
    input  logic            i_arvalid,
    output logic            o_arready,
    output logic [DW-1:0]   o_rdata,
    output logic [1:0]      o_rresp,
    output logic            o_rvalid,
    input  logic            i_rready,
    output logic [AW-1:0]   o_wb_adr,
    output logic [DW-1:0]   o_wb_dat,
    output logic [DW/8-1:0] o_wb_sel,
    output logic            o_wb_we,
    output logic            o_wb_cyc,
    input  logic [DW-1:0]   i_wb_rdt,
    input  logic            i_wb_ack,
    input  logic            i_wb_err
);

    localparam int SW = DW / 8;
    // A disabled timeout still needs a legal one-bit counter.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUS, WRESP, RRESP} state_t;

    state_t          state_q;
    logic            awFull_q, wFull_q, arFull_q;
    logic            awFull_d, wFull_d, arFull_d;
    logic            awReady_q, wReady_q, arReady_q;
    logic [AW-1:0]   awAddr_q, arAddr_q;
    logic [DW-1:0]   wData_q;
    logic [SW-1:0]   wStrb_q;
    logic            lastWrite_q;
    logic [AW-1:0]   wbAdr_q;
    logic [DW-1:0]   wbDat_q;
    logic [SW-1:0]   wbSel_q;
    logic            wbWe_q, wbCyc_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      resp_q;
    logic [DW-1:0]   rdata_q;
    logic            bvalid_q, rvalid_q;
    logic            grantWrite, grantRead, timedOut;

    // Arbitration and next fill state of the holding registers.
    always_comb begin
        grantWrite = (state_q == IDLE) && awFull_q && wFull_q
                     && (!arFull_q || !lastWrite_q);
        grantRead  = (state_q == IDLE) && arFull_q && !grantWrite;
        timedOut   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

        awFull_d = awFull_q;
        wFull_d  = wFull_q;
        arFull_d = arFull_q;
        if (grantWrite) begin
            awFull_d = 1'b0;
            wFull_d  = 1'b0;
        end else begin
            if (i_awvalid && awReady_q) awFull_d = 1'b1;
            if (i_wvalid && wReady_q)   wFull_d  = 1'b1;
        end
        if (grantRead) begin
            arFull_d = 1'b0;
        end else if (i_arvalid && arReady_q) begin
            arFull_d = 1'b1;
        end
    end

    // Holding registers capture on every handshake; readies track next-state emptiness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awFull_q  <= 1'b0;
            wFull_q   <= 1'b0;
            arFull_q  <= 1'b0;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            arReady_q <= 1'b0;
            awAddr_q  <= '0;
            arAddr_q  <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
        end else begin
            awFull_q  <= awFull_d;
            wFull_q   <= wFull_d;
            arFull_q  <= arFull_d;
            awReady_q <= !awFull_d;
            wReady_q  <= !wFull_d;
            arReady_q <= !arFull_d;
            if (i_awvalid && awReady_q) awAddr_q <= i_awaddr;
            if (i_arvalid && arReady_q) arAddr_q <= i_araddr;
            if (i_wvalid && wReady_q) begin
                wData_q <= i_wdata;
                wStrb_q <= i_wstrb;
            end
        end
    end

    // Transaction FSM: issue one Wishbone cycle, then hold the AXI response until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastWrite_q <= 1'b0;
            wbAdr_q     <= '0;
            wbDat_q     <= '0;
            wbSel_q     <= '0;
            wbWe_q      <= 1'b0;
            wbCyc_q     <= 1'b0;
            cnt_q       <= '0;
            resp_q      <= 2'b00;
            rdata_q     <= '0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantWrite) begin
                        wbAdr_q     <= awAddr_q & ~AW'(SW - 1);
                        wbDat_q     <= wData_q;
                        wbSel_q     <= wStrb_q;
                        wbWe_q      <= 1'b1;
                        wbCyc_q     <= 1'b1;
                        cnt_q       <= '0;
                        lastWrite_q <= 1'b1;
                        state_q     <= BUS;
                    end else if (grantRead) begin
                        wbAdr_q     <= arAddr_q & ~AW'(SW - 1);
                        wbSel_q     <= '1;
                        wbWe_q      <= 1'b0;
                        wbCyc_q     <= 1'b1;
                        cnt_q       <= '0;
                        lastWrite_q <= 1'b0;
                        state_q     <= BUS;
                    end
                end
                BUS: begin
                    if (i_wb_err || i_wb_ack || timedOut) begin
                        if (i_wb_err) begin
                            resp_q  <= 2'b10;
                            rdata_q <= '0;
                        end else if (i_wb_ack) begin
                            resp_q  <= 2'b00;
                            rdata_q <= wbWe_q ? '0 : i_wb_rdt;
                        end else begin
                            resp_q  <= 2'b11;
                            rdata_q <= '0;
                        end
                        wbCyc_q  <= 1'b0;
                        wbWe_q   <= 1'b0;
                        bvalid_q <= wbWe_q;
                        rvalid_q <= !wbWe_q;
                        state_q  <= wbWe_q ? WRESP : RRESP;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WRESP: begin
                    if (i_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RRESP: begin
                    if (i_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_awready = awReady_q;
    assign o_wready  = wReady_q;
    assign o_arready = arReady_q;
    assign o_bresp   = resp_q;
    assign o_bvalid  = bvalid_q;
    assign o_rdata   = rdata_q;
    assign o_rresp   = resp_q;
    assign o_rvalid  = rvalid_q;
    assign o_wb_adr  = wbAdr_q;
    assign o_wb_dat  = wbDat_q;
    assign o_wb_sel  = wbSel_q;
    assign o_wb_we   = wbWe_q;
    assign o_wb_cyc  = wbCyc_q;

endmodule
